cnt_bank: RTL and testbench

- Parametrised multi-channel event counter bank; the successor to the fixed single 32-bit split counter.
- Each channel counts single-cycle enable pulses in a CNT_W-bit counter. The counter is split into a low segment and a high segment, and the carry between them is pre-computed in a register so that wide counters close timing.
- A registered read port returns the value and overflow flag of one channel, with optional clear-on-read.
- Sits beside datapath blocks (DMA, PCIe/MSI-X paths) and feeds the statistics register file.

---
 rtl/cnt_bank.sv | 121 ++++++++++++
 tb/tb_cnt_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_bank.sv
// Multi-channel event counter bank with split low/high segments, a precomputed
// carry and a registered read port. Define CNT_BANK_SAT_EN for saturating counters.
module cnt_bank #(
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 32,
    parameter int LO_W   = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              a_clr,
    input  logic              s_clr,
    input  logic [CH_NUM-1:0] en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_clr,
    output logic              rd_vld,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic [CH_NUM-1:0] ovf
);

    localparam int HI_W = CNT_W - LO_W;
    localparam logic [LO_W-1:0] LO_PRE = ~LO_W'(1);
    localparam logic [HI_W-1:0] HI_PRE = ~HI_W'(1);

    logic [CNT_W-1:0]  w_cnt [CH_NUM];
    logic [CH_NUM-1:0] w_rdClr;
    logic [CNT_W-1:0]  w_rdVal;
    logic              w_rdOvf;

    for (genvar g = 0; g < CH_NUM; g++) begin : gCh
        logic [LO_W-1:0] r_lo;
        logic [HI_W-1:0] r_hi;
        logic            r_loMax;
        logic            r_hiMax;
        logic            r_ovf;

        assign w_rdClr[g] = rd_en & rd_clr & (rd_addr == ADDR_W'(g));
        assign w_cnt[g]   = {r_hi, r_lo};
        assign ovf[g]     = r_ovf;

        // r_loMax/r_hiMax mirror "segment is all ones" one cycle early, so the
        // high-segment increment never waits on a wide low-segment compare.
        always_ff @(posedge clk or posedge a_clr) begin
            if (a_clr) begin
                r_lo    <= '0;
                r_hi    <= '0;
                r_loMax <= 1'b0;
                r_hiMax <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (s_clr) begin
                r_lo    <= '0;
                r_hi    <= '0;
                r_loMax <= 1'b0;
                r_hiMax <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_rdClr[g]) begin
                r_hi    <= '0;
                r_hiMax <= 1'b0;
                r_ovf   <= 1'b0;
                if (en[g]) begin
                    r_lo    <= LO_W'(1);
                    r_loMax <= (LO_W == 1);
                end else begin
                    r_lo    <= '0;
                    r_loMax <= 1'b0;
                end
            end else if (en[g]) begin
`ifdef CNT_BANK_SAT_EN
                if (r_loMax && r_hiMax) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_lo    <= r_lo + 1'b1;
                    r_loMax <= (r_lo == LO_PRE);
                    if (r_loMax) begin
                        r_hi    <= r_hi + 1'b1;
                        r_hiMax <= (r_hi == HI_PRE);
                    end
                end
`else
                r_lo    <= r_lo + 1'b1;
                r_loMax <= (r_lo == LO_PRE);
                if (r_loMax) begin
                    r_hi    <= r_hi + 1'b1;
                    r_hiMax <= (r_hi == HI_PRE);
                end
                if (r_loMax && r_hiMax) begin
                    r_ovf <= 1'b1;
                end
`endif
            end
        end
    end

    // Unmatched addresses fall through to the zero default.
    always_comb begin
        w_rdVal = '0;
        w_rdOvf = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                w_rdVal = w_cnt[i];
                w_rdOvf = ovf[i];
            end
        end
    end

    always_ff @(posedge clk or posedge a_clr) begin
        if (a_clr) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
            rd_ovf  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= w_rdVal;
                rd_ovf  <= w_rdOvf;
            end
        end
    end

endmodule

// File: tb/tb_cnt_bank.sv
// Scoreboard bench for cnt_bank: a 32-bit/8-channel instance (A) and an
// 8-bit/5-channel instance (B) for wrap, saturation and out-of-range reads.
module tb_cnt_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aClr = 1'b0;
    logic        sClr = 1'b0;

    logic [7:0]  enA = '0;
    logic        rdEnA = 1'b0, rdClrA = 1'b0;
    logic [2:0]  rdAddrA = '0;
    logic        rdVldA, rdOvfA;
    logic [31:0] rdDataA;
    logic [7:0]  ovfA;

    logic [4:0]  enB = '0;
    logic        rdEnB = 1'b0, rdClrB = 1'b0;
    logic [2:0]  rdAddrB = '0;
    logic        rdVldB, rdOvfB;
    logic [7:0]  rdDataB;
    logic [4:0]  ovfB;

    int vectors = 0;
    int errors  = 0;
    int tagCnt  = 0;

    typedef struct packed {
        logic [15:0] tag;
        logic        ovf;
        logic [31:0] data;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];

`ifdef CNT_BANK_SAT_EN
    localparam logic [31:0] WRAP_VAL = 32'h0000_00FF;
`else
    localparam logic [31:0] WRAP_VAL = 32'h0000_0001;
`endif

    cnt_bank #(.CH_NUM(8), .CNT_W(32), .LO_W(16), .ADDR_W(3)) dutA (
        .clk(clk), .a_clr(aClr), .s_clr(sClr), .en(enA),
        .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_clr(rdClrA),
        .rd_vld(rdVldA), .rd_data(rdDataA), .rd_ovf(rdOvfA), .ovf(ovfA)
    );

    cnt_bank #(.CH_NUM(5), .CNT_W(8), .LO_W(3), .ADDR_W(3)) dutB (
        .clk(clk), .a_clr(aClr), .s_clr(sClr), .en(enB),
        .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_clr(rdClrB),
        .rd_vld(rdVldB), .rd_data(rdDataB), .rd_ovf(rdOvfB), .ovf(ovfB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read; the expectation is queued once the capturing edge has passed.
    task automatic applyStimulus(input bit onB, input logic [2:0] addr, input bit clr,
                                 input logic [31:0] expData, input bit expOvf);
        exp_t e;
        if (onB) begin
            rdEnB = 1'b1; rdAddrB = addr; rdClrB = clr;
        end else begin
            rdEnA = 1'b1; rdAddrA = addr; rdClrA = clr;
        end
        tick();
        e.tag  = 16'(tagCnt);
        e.data = expData;
        e.ovf  = expOvf;
        tagCnt++;
        if (onB) qB.push_back(e);
        else     qA.push_back(e);
        rdEnA = 1'b0; rdClrA = 1'b0;
        rdEnB = 1'b0; rdClrB = 1'b0;
    endtask

    task automatic pulseEnable(input bit onB, input logic [7:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            if (onB) enB = mask[4:0];
            else     enA = mask;
            tick();
            enA = '0;
            enB = '0;
            tick();
        end
    endtask

    // A queued expectation must be met by rd_vld on the very next falling edge.
    always @(negedge clk) begin : monA
        exp_t e;
        if (!aClr) begin
            if (qA.size() != 0) begin
                e = qA.pop_front();
                checkOutput($sformatf("rdA#%0d vld", e.tag), {31'b0, rdVldA}, 32'd1);
                checkOutput($sformatf("rdA#%0d data", e.tag), rdDataA, e.data);
                checkOutput($sformatf("rdA#%0d ovf", e.tag), {31'b0, rdOvfA}, {31'b0, e.ovf});
            end else if (rdVldA) begin
                checkOutput("rdA spurious vld", {31'b0, rdVldA}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : monB
        exp_t e;
        if (!aClr) begin
            if (qB.size() != 0) begin
                e = qB.pop_front();
                checkOutput($sformatf("rdB#%0d vld", e.tag), {31'b0, rdVldB}, 32'd1);
                checkOutput($sformatf("rdB#%0d data", e.tag), {24'b0, rdDataB}, e.data);
                checkOutput($sformatf("rdB#%0d ovf", e.tag), {31'b0, rdOvfB}, {31'b0, e.ovf});
            end else if (rdVldB) begin
                checkOutput("rdB spurious vld", {31'b0, rdVldB}, 32'd0);
            end
        end
    end

    initial begin
        #1 aClr = 1'b1;
        #11;
        checkOutput("reset rd_vld", {30'b0, rdVldB, rdVldA}, 32'd0);
        checkOutput("reset rd_data A", rdDataA, 32'd0);
        checkOutput("reset rd_data B", {24'b0, rdDataB}, 32'd0);
        checkOutput("reset rd_ovf", {30'b0, rdOvfB, rdOvfA}, 32'd0);
        checkOutput("reset ovf", {19'b0, ovfB, ovfA}, 32'd0);
        tick();
        aClr = 1'b0;
        tick();

        $display("[TB] basic count and back-to-back reads");
        pulseEnable(1'b0, 8'h01, 5);
        applyStimulus(1'b0, 3'd0, 1'b0, 32'd5, 1'b0);
        for (int i = 1; i < 8; i++) applyStimulus(1'b0, 3'(i), 1'b0, 32'd0, 1'b0);

        $display("[TB] segment carry across 0xFFFF");
        enA = 8'h02;
        repeat (65535) tick();
        applyStimulus(1'b0, 3'd1, 1'b0, 32'h0000_FFFF, 1'b0);
        applyStimulus(1'b0, 3'd1, 1'b0, 32'h0001_0000, 1'b0);
        enA = 8'h00;
        applyStimulus(1'b0, 3'd1, 1'b0, 32'h0001_0001, 1'b0);

        $display("[TB] read-clear collision");
        pulseEnable(1'b0, 8'h08, 10);
        enA = 8'h0C;
        applyStimulus(1'b0, 3'd3, 1'b1, 32'd10, 1'b0);
        enA = 8'h00;
        checkOutput("ovfA after read-clear", {24'b0, ovfA}, 32'd0);
        applyStimulus(1'b0, 3'd3, 1'b0, 32'd1, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 32'd1, 1'b0);
        applyStimulus(1'b0, 3'd0, 1'b0, 32'd5, 1'b0);

        $display("[TB] s_clr against count and read");
        pulseEnable(1'b0, 8'h10, 7);
        sClr = 1'b1;
        enA  = 8'hFF;
        applyStimulus(1'b0, 3'd4, 1'b0, 32'd7, 1'b0);
        sClr = 1'b0;
        enA  = 8'h00;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'(i), 1'b0, 32'd0, 1'b0);
        checkOutput("ovfA after s_clr", {24'b0, ovfA}, 32'd0);

        $display("[TB] 8-bit wrap or saturate");
        enB = 5'b00100;
        repeat (254) tick();
        enB = 5'b00000;
        pulseEnable(1'b1, 8'h04, 1);
        applyStimulus(1'b1, 3'd2, 1'b0, 32'hFF, 1'b0);
        checkOutput("ovfB at all ones", {27'b0, ovfB}, 32'd0);
        pulseEnable(1'b1, 8'h04, 2);
        checkOutput("ovfB after overflow", {27'b0, ovfB}, 32'h04);
        applyStimulus(1'b1, 3'd2, 1'b1, WRAP_VAL, 1'b1);
        applyStimulus(1'b1, 3'd2, 1'b0, 32'd0, 1'b0);
        checkOutput("ovfB after read-clear", {27'b0, ovfB}, 32'd0);

        $display("[TB] out-of-range reads");
        pulseEnable(1'b1, 8'h1F, 3);
        applyStimulus(1'b1, 3'd6, 1'b1, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd7, 1'b1, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd5, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 32'd3, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0, 32'd3, 1'b0);
        applyStimulus(1'b1, 3'd4, 1'b0, 32'd3, 1'b0);

        $display("[TB] asynchronous reset mid-count");
        pulseEnable(1'b0, 8'h20, 2);
        applyStimulus(1'b0, 3'd5, 1'b0, 32'd2, 1'b0);
        enA = 8'h20;
        tick();
        tick();
        #2 aClr = 1'b1;
        #1;
        checkOutput("async rd_vld", {30'b0, rdVldB, rdVldA}, 32'd0);
        checkOutput("async rd_data A", rdDataA, 32'd0);
        checkOutput("async rd_data B", {24'b0, rdDataB}, 32'd0);
        checkOutput("async ovf", {19'b0, ovfB, ovfA}, 32'd0);
        tick();
        aClr = 1'b0;
        enA  = 8'h00;
        applyStimulus(1'b0, 3'd5, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 32'd0, 1'b0);
        tick();
        tick();

        checkOutput("pending reads A", 32'(qA.size()), 32'd0);
        checkOutput("pending reads B", 32'(qB.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
